// File: rtl/irq_debouncer_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared constants, types and helpers for the interrupt debouncer.
//   IRQ_NUM_POW_DEFAULT  : default log2 of the interrupt line count
//   SYNC_STAGES_MIN/MAX  : legal synchroniser depth range
//   DEBOUNCE_MIN/MAX     : legal stability-count range
//   cnt_width()          : stability counter width for a given cycle count
//   irq_vec_t            : one bit per interrupt line at the default line count
// ----------------------------------------------------------------------------
package irq_pkg;

  localparam int unsigned IRQ_NUM_POW_DEFAULT = 4;
  localparam int unsigned IRQ_NUM_DEFAULT     = 2 ** IRQ_NUM_POW_DEFAULT;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  localparam int unsigned DEBOUNCE_MIN = 1;
  localparam int unsigned DEBOUNCE_MAX = 65535;

  typedef logic [IRQ_NUM_DEFAULT-1:0] irq_vec_t;

  // Counter must hold 0..cycles-1; a single bit is kept even when cycles==1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : irq_pkg

// File: rtl/irq_debouncer_line.sv
// ----------------------------------------------------------------------------
// irq_debounce_line
// One interrupt line: polarity normalisation, synchroniser chain, stability
// counter, accepted-level flop and a one-cycle rising strobe.
// Ports:
//   clk_i      : tile clock
//   rst_i      : synchronous active-low reset
//   raw        : raw asynchronous interrupt input
//   debounced  : accepted active-high level (registered)
//   rise       : one-cycle strobe in the first cycle debounced reads 1
// ----------------------------------------------------------------------------
module irq_debounce_line
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        POLARITY        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw,
  output logic debounced,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic                   norm;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   rise_q;
  logic                   rise_d;

  // Active-low lines are flipped before they enter the clock domain.
  assign norm = raw ^ POLARITY;
  assign s    = sync_q[SYNC_STAGES-1];

  // Stability tracking: any agreement with the accepted level clears the run.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s;
      cnt_d    = '0;
      rise_d   = s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any partial count and synchroniser state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], norm};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign debounced = stable_q;
  assign rise      = rise_q;

endmodule : irq_debounce_line

// File: rtl/irq_debouncer.sv
// ----------------------------------------------------------------------------
// irq_debouncer
// Conditions N raw asynchronous interrupt lines into glitch-free active-high
// levels on the tile clock, plus a one-cycle strobe per line on each accepted
// 0->1 transition. Lines are fully independent.
// Ports:
//   clk_i            : tile clock, all state on rising edge
//   rst_i            : synchronous active-low reset
//   irq_raw_bi       : raw asynchronous interrupt lines (N bits)
//   irq_debounced_bo : debounced active-high levels (registered)
//   irq_rise_bo      : one-cycle strobe on debounced 0->1 (registered)
// ----------------------------------------------------------------------------
module irq_debouncer
  import irq_pkg::*;
#(
  parameter int unsigned                      IRQ_NUM_POW     = IRQ_NUM_POW_DEFAULT,
  parameter int unsigned                      SYNC_STAGES     = 2,
  parameter int unsigned                      DEBOUNCE_CYCLES = 4,
  parameter logic [(2 ** IRQ_NUM_POW)-1:0]    IRQ_POLARITY    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [(2 ** IRQ_NUM_POW)-1:0]  irq_raw_bi,
  output logic [(2 ** IRQ_NUM_POW)-1:0]  irq_debounced_bo,
  output logic [(2 ** IRQ_NUM_POW)-1:0]  irq_rise_bo
);

  localparam int unsigned N = 2 ** IRQ_NUM_POW;

  // Reject unsupported configurations at elaboration.
  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("irq_debouncer: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end
  if ((DEBOUNCE_CYCLES < DEBOUNCE_MIN) || (DEBOUNCE_CYCLES > DEBOUNCE_MAX)) begin : g_bad_deb
    $error("irq_debouncer: DEBOUNCE_CYCLES=%0d outside %0d..%0d",
           DEBOUNCE_CYCLES, DEBOUNCE_MIN, DEBOUNCE_MAX);
  end

  // One independent conditioner per line, no arbitration between lines.
  for (genvar i = 0; i < N; i++) begin : g_line
    irq_debounce_line #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .POLARITY        (IRQ_POLARITY[i])
    ) u_line (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .raw       (irq_raw_bi[i]),
      .debounced (irq_debounced_bo[i]),
      .rise      (irq_rise_bo[i])
    );
  end

endmodule : irq_debouncer

// File: tb/tb_irq_debouncer.sv
// ----------------------------------------------------------------------------
// tb_irq_debouncer
// Two instances share clock and reset: dut_a with all lines active-high and
// dut_b with line 0 active-low. A reference model tracks, per line, how many
// consecutive synchronised samples disagree with the accepted level.
// ----------------------------------------------------------------------------
module tb_irq_debouncer;
  import irq_pkg::*;

  localparam int unsigned S     = 2;
  localparam int unsigned D     = 4;
  localparam int unsigned LAT   = S + D;
  localparam irq_vec_t    POL_B = 16'h0001;

  typedef struct {
    logic     rst;
    irq_vec_t raw;
    irq_vec_t exp_bo;
    irq_vec_t exp_rise;
  } vec_t;

  logic     clk = 1'b0;
  logic     rst_i;
  irq_vec_t raw_a, raw_b;
  irq_vec_t bo_a, rise_a, bo_b, rise_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  irq_vec_t m_hist   [2][S];
  irq_vec_t m_stable [2];
  irq_vec_t m_rise   [2];
  int       m_run    [2][16];

  vec_t tbl[$];

  always #5 clk = ~clk;

  irq_debouncer #(
    .IRQ_NUM_POW(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .IRQ_POLARITY(16'h0000)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_i), .irq_raw_bi(raw_a),
    .irq_debounced_bo(bo_a), .irq_rise_bo(rise_a)
  );

  irq_debouncer #(
    .IRQ_NUM_POW(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .IRQ_POLARITY(POL_B)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_i), .irq_raw_bi(raw_b),
    .irq_debounced_bo(bo_b), .irq_rise_bo(rise_b)
  );

  task automatic check(input string name, input irq_vec_t act, input irq_vec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a sample taken S edges ago is the synchronised value; the level is
  // accepted once D consecutive such samples disagree with the current level.
  task automatic model_edge(input int inst, input irq_vec_t raw, input logic rst);
    irq_vec_t s;
    irq_vec_t pol;
    pol = (inst == 1) ? POL_B : '0;
    if (!rst) begin
      for (int k = 0; k < S; k++) m_hist[inst][k] = '0;
      m_stable[inst] = '0;
      m_rise[inst]   = '0;
      for (int i = 0; i < 16; i++) m_run[inst][i] = 0;
    end else begin
      s = m_hist[inst][S-1];
      m_rise[inst] = '0;
      for (int i = 0; i < 16; i++) begin
        if (s[i] == m_stable[inst][i]) begin
          m_run[inst][i] = 0;
        end else begin
          m_run[inst][i] = m_run[inst][i] + 1;
          if (m_run[inst][i] == D) begin
            m_stable[inst][i] = s[i];
            m_rise[inst][i]   = s[i];
            m_run[inst][i]    = 0;
          end
        end
      end
      for (int k = S - 1; k > 0; k--) m_hist[inst][k] = m_hist[inst][k-1];
      m_hist[inst][0] = raw ^ pol;
    end
  endtask

  // One clock: model consumes the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge(0, raw_a, rst_i);
    model_edge(1, raw_b, rst_i);
    #1;
    check("model_bo_a",   bo_a,   m_stable[0]);
    check("model_rise_a", rise_a, m_rise[0]);
    check("model_bo_b",   bo_b,   m_stable[1]);
    check("model_rise_b", rise_b, m_rise[1]);
  endtask

  task automatic add(input logic r, input irq_vec_t raw, input irq_vec_t bo,
                     input irq_vec_t ri, input int n);
    vec_t v;
    v.rst = r; v.raw = raw; v.exp_bo = bo; v.exp_rise = ri;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    int       cnt;
    logic     seen;
    irq_vec_t m;

    rst_i = 1'b0;
    raw_a = '0;
    raw_b = 16'h0001;

    // Table: reset, idle, line 3 rise and fall with exact latency.
    add(1'b0, 16'h0000, 16'h0000, 16'h0000, 2);
    add(1'b1, 16'h0000, 16'h0000, 16'h0000, 20);
    add(1'b1, 16'h0008, 16'h0000, 16'h0000, 5);
    add(1'b1, 16'h0008, 16'h0008, 16'h0008, 1);
    add(1'b1, 16'h0008, 16'h0008, 16'h0000, 3);
    add(1'b1, 16'h0000, 16'h0008, 16'h0000, 5);
    add(1'b1, 16'h0000, 16'h0000, 16'h0000, 4);
    foreach (tbl[j]) begin
      rst_i = tbl[j].rst;
      raw_a = tbl[j].raw;
      tick();
      check("tbl_bo",   bo_a,   tbl[j].exp_bo);
      check("tbl_rise", rise_a, tbl[j].exp_rise);
    end

    // Glitch rejection on line 7: 3 high, 1 low, 3 high never accepted.
    seen = 1'b0;
    for (int i = 0; i < 13; i++) begin
      raw_a[7] = (i < 3) || (i >= 4 && i < 7);
      tick();
      if (bo_a[7]) seen = 1'b1;
    end
    check("glitch_no_assert", irq_vec_t'(seen), 16'h0000);
    // Four steady samples are enough.
    seen = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      raw_a[7] = (i < 4);
      tick();
      if (bo_a[7] && !seen) begin seen = 1'b1; cnt = i + 1; end
    end
    check("glitch_accept_edge", irq_vec_t'(cnt), irq_vec_t'(LAT));
    for (int i = 0; i < 8; i++) tick();

    // Active-low line 0 on dut_b: idle raw 1 reads 0, raw 0 asserts.
    check("pol_idle", bo_b & 16'h0001, 16'h0000);
    raw_b[0] = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20 && cnt == 0; i++) begin
      tick();
      if (bo_b[0]) cnt = i;
    end
    check("pol_latency",   irq_vec_t'(cnt), irq_vec_t'(LAT));
    check("pol_rise",      rise_b & 16'h0001, 16'h0001);
    tick();
    check("pol_rise_once", rise_b & 16'h0001, 16'h0000);
    raw_b[0] = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Reset mid-count on line 5 discards the partial count.
    raw_a[5] = 1'b1;
    for (int i = 0; i < S + 3; i++) tick();
    rst_i = 1'b0;
    tick();
    check("rst_mid_bo", bo_a & 16'h0020, 16'h0000);
    rst_i = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 20 && cnt == 0; i++) begin
      tick();
      if (bo_a[5]) cnt = i;
    end
    check("rst_restart_latency", irq_vec_t'(cnt), irq_vec_t'(LAT));
    raw_a = '0;
    for (int i = 0; i < 8; i++) tick();

    // All lines together.
    check("all_idle", bo_a, 16'h0000);
    raw_a = 16'hFFFF;
    cnt = 0;
    for (int i = 1; i <= 20 && cnt == 0; i++) begin
      tick();
      if (bo_a != 16'h0000) cnt = i;
    end
    check("all_latency", irq_vec_t'(cnt), irq_vec_t'(LAT));
    check("all_bo",      bo_a,   16'hFFFF);
    check("all_rise",    rise_a, 16'hFFFF);
    tick();
    check("all_rise_once", rise_a, 16'h0000);

    // Randomised traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 199) != 0);
      m = irq_vec_t'($urandom & $urandom & $urandom);
      raw_a = raw_a ^ m;
      m = irq_vec_t'($urandom & $urandom & $urandom);
      raw_b = raw_b ^ m;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_irq_debouncer
